conv5_window_gen: RTL

- Streaming 5x5 sliding-window generator that feeds the 25-tap convolution neuron.
- Accepts a raster-order pixel stream, one 8-bit pixel per handshake, and buffers the four previous image rows in line buffers.
- Emits every valid 5x5 window (no padding, stride 1) as 25 parallel taps, aligned to the neuron's in0..in24 ordering.

---
 rtl/conv5_window_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/conv5_window_gen.sv
// conv5_window_gen: streaming 5x5 sliding-window generator.
// Takes one raster-order pixel per handshake and keeps the four previous
// image rows in line buffers. Every valid 5x5 window (no padding, stride 1)
// is presented as 25 parallel taps: tap k = r*5+c, with r=0 the oldest row
// and c=0 the oldest column. A single output register stage carries
// win_valid/win_last/win_data.
module conv5_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [25*DATA_W-1:0]  win_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  win_last
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN_0 = COL_W'(4);
  localparam logic [ROW_W-1:0] ROW_WIN_0 = ROW_W'(4);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;

  // Line buffers: lb0 holds the previous row, lb3 the row four back.
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] lb3 [IMG_W];

  // Window register, win[r][c]; r=0 oldest row, c=0 oldest column.
  logic [DATA_W-1:0] win [5][5];

  // Incoming rightmost column, oldest row first.
  logic [DATA_W-1:0] new_col [5];

  logic accept;
  logic col_end;
  logic row_end;
  logic win_pos;
  logic frame_end;

  // Single output stage: accept whenever the held window is empty or leaving.
  // Held low while reset is asserted.
  assign pix_ready = rst_n & (~win_valid | win_ready);
  assign accept    = pix_valid & pix_ready;

  assign col_end   = (col == COL_LAST);
  assign row_end   = (row == ROW_LAST);
  assign win_pos   = (row >= ROW_WIN_0) && (col >= COL_WIN_0);
  assign frame_end = row_end & col_end;

  // Gather the new window column from the line buffers and the live pixel.
  always_comb begin
    new_col[0] = lb3[col];
    new_col[1] = lb2[col];
    new_col[2] = lb1[col];
    new_col[3] = lb0[col];
    new_col[4] = pix_in;
  end

  // Raster position counters; advance only on an accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Line buffer shift down one row at the current column (contents not reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      lb3[col] <= lb2[col];
      lb2[col] <= lb1[col];
      lb1[col] <= lb0[col];
      lb0[col] <= pix_in;
    end
  end

  // Window register: shift left one column and load the new rightmost column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][4] <= new_col[r];
      end
    end
  end

  // Window valid/last: a new window replaces the held one on the same edge;
  // otherwise a consumed window empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (accept) begin
      win_valid <= win_pos;
      win_last  <= win_pos & frame_end;
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

  // Flatten the window register into the tap bus, tap k = r*5+c.
  always_comb begin
    win_data = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        win_data[(r*5+c)*DATA_W +: DATA_W] = win[r][c];
      end
    end
  end

endmodule
